// File: rtl/pe_ns_pkg.sv
// pe_ns_pkg: namespace codes, sequencer states and namespace check shared by the load controller.
package pe_ns_pkg;
    localparam logic [2:0] NS_INST     = 3'd0;
    localparam logic [2:0] NS_DATA     = 3'd1;
    localparam logic [2:0] NS_WEIGHT   = 3'd2;
    localparam logic [2:0] NS_GRADIENT = 3'd3;
    localparam logic [2:0] NS_META     = 3'd4;

    typedef enum logic {IDLE, BURST} state_t;

    function automatic logic ns_valid(input logic [2:0] ns);
        return ns <= NS_META;
    endfunction
endpackage

// File: rtl/pe_ns_rr_arb.sv
// pe_ns_rr_arb: two-requester round robin; req[0] is writeback, req[1] is burst, last winner yields.
module pe_ns_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last;

    assign gnt[0] = req[0] && (!req[1] || last);
    assign gnt[1] = req[1] && (!req[0] || !last);

    always_ff @(posedge clk) begin
        if (reset)
            last <= 1'b1;
        else if (|gnt)
            last <= gnt[1];
    end
endmodule

// File: rtl/pe_ns_load_ctrl.sv
// pe_ns_load_ctrl: burst load sequencer sharing the namespace write ports with PE writeback.
module pe_ns_load_ctrl
    import pe_ns_pkg::*;
#(
    parameter int dataLen       = 32,
    parameter int instLen       = 32,
    parameter int dataAddrLen   = 6,
    parameter int weightAddrLen = 6,
    parameter int metaAddrLen   = 2,
    parameter int addrLen       = 6,
    parameter int cntLen        = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_ns,
    input  logic [addrLen-1:0]       cmd_base,
    input  logic [cntLen-1:0]        cmd_count,
    input  logic                     wdata_valid,
    output logic                     wdata_ready,
    input  logic [dataLen-1:0]       wdata,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [2:0]               wb_ns,
    input  logic [addrLen-1:0]       wb_addr,
    input  logic [dataLen-1:0]       wb_data,
    input  logic                     inst_fifo_full,
    output logic                     inst_wrt,
    output logic [instLen-1:0]       inst_in,
    output logic                     data_wrt,
    output logic [dataAddrLen-1:0]   data_wrt_addr,
    output logic [dataLen-1:0]       data_in,
    output logic                     weight_wrt,
    output logic [weightAddrLen-1:0] weight_wrt_addr,
    output logic [dataLen-1:0]       weight_in,
    output logic                     gradient_wrt,
    output logic [weightAddrLen-1:0] gradient_wrt_addr,
    output logic [dataLen-1:0]       gradient_in,
    output logic                     meta_wrt,
    output logic [metaAddrLen-1:0]   meta_wrt_addr,
    output logic [dataLen-1:0]       meta_in,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    state_t               state;
    logic [2:0]           ns_q;
    logic [addrLen-1:0]   base_q, b_addr;
    logic [cntLen-1:0]    cnt_q, off_q;
    logic                 in_burst, inst_ok, wb_legal, b_req, conflict;
    logic                 cmd_fire, cmd_ok, b_fire, wb_fire, wb_wr, last_word;
    logic [1:0]           gnt;
    logic [4:1]           b_hit, w_hit;

    assign in_burst  = state == BURST;
    // inst_wrt blocks back-to-back writes: the fifo full flag lags one write behind
    assign inst_ok   = !inst_fifo_full && !inst_wrt;
    assign wb_legal  = ns_valid(wb_ns) && wb_ns != NS_INST;
    assign b_req     = in_burst && wdata_valid && (ns_q != NS_INST || inst_ok);
    assign conflict  = b_req && wb_valid && wb_legal && wb_ns == ns_q;

    assign cmd_ready   = !in_burst;
    assign wdata_ready = in_burst && (ns_q == NS_INST ? inst_ok : !(conflict && !gnt[1]));
    assign wb_ready    = !(conflict && !gnt[0]);

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign cmd_ok    = ns_valid(cmd_ns);
    assign b_fire    = wdata_valid && wdata_ready;
    assign wb_fire   = wb_valid && wb_ready;
    assign wb_wr     = wb_fire && wb_legal;
    assign last_word = off_q == cnt_q - cntLen'(1);
    assign b_addr    = base_q + addrLen'(off_q);
    assign busy      = in_burst;

    pe_ns_rr_arb u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({conflict, conflict}),
        .gnt   (gnt)
    );

    always_comb begin
        b_hit = '0;
        w_hit = '0;
        for (int i = 1; i <= 4; i++) begin
            b_hit[i] = b_fire && ns_q == 3'(i);
            w_hit[i] = wb_wr && wb_ns == 3'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            ns_q              <= '0;
            base_q            <= '0;
            cnt_q             <= '0;
            off_q             <= '0;
            done              <= 1'b0;
            err               <= 1'b0;
            inst_wrt          <= 1'b0;
            inst_in           <= '0;
            data_wrt          <= 1'b0;
            data_wrt_addr     <= '0;
            data_in           <= '0;
            weight_wrt        <= 1'b0;
            weight_wrt_addr   <= '0;
            weight_in         <= '0;
            gradient_wrt      <= 1'b0;
            gradient_wrt_addr <= '0;
            gradient_in       <= '0;
            meta_wrt          <= 1'b0;
            meta_wrt_addr     <= '0;
            meta_in           <= '0;
        end else begin
            done     <= (cmd_fire && cmd_ok && cmd_count == '0) || (b_fire && last_word);
            err      <= (cmd_fire && !cmd_ok) || (wb_fire && !wb_legal);
            inst_wrt <= b_fire && ns_q == NS_INST;
            if (b_fire && ns_q == NS_INST)
                inst_in <= wdata[instLen-1:0];
            if (cmd_fire && cmd_ok && cmd_count != '0) begin
                state  <= BURST;
                ns_q   <= cmd_ns;
                base_q <= cmd_base;
                cnt_q  <= cmd_count;
                off_q  <= '0;
            end else if (b_fire) begin
                off_q <= off_q + cntLen'(1);
                if (last_word)
                    state <= IDLE;
            end
            // same-namespace hits are exclusive through the arbiter, so burst-first muxing is safe
            data_wrt <= b_hit[1] || w_hit[1];
            if (b_hit[1] || w_hit[1]) begin
                data_wrt_addr <= dataAddrLen'(b_hit[1] ? b_addr : wb_addr);
                data_in       <= b_hit[1] ? wdata : wb_data;
            end
            weight_wrt <= b_hit[2] || w_hit[2];
            if (b_hit[2] || w_hit[2]) begin
                weight_wrt_addr <= weightAddrLen'(b_hit[2] ? b_addr : wb_addr);
                weight_in       <= b_hit[2] ? wdata : wb_data;
            end
            gradient_wrt <= b_hit[3] || w_hit[3];
            if (b_hit[3] || w_hit[3]) begin
                gradient_wrt_addr <= weightAddrLen'(b_hit[3] ? b_addr : wb_addr);
                gradient_in       <= b_hit[3] ? wdata : wb_data;
            end
            meta_wrt <= b_hit[4] || w_hit[4];
            if (b_hit[4] || w_hit[4]) begin
                meta_wrt_addr <= metaAddrLen'(b_hit[4] ? b_addr : wb_addr);
                meta_in       <= b_hit[4] ? wdata : wb_data;
            end
        end
    end
endmodule

// File: tb/tb_pe_ns_load_ctrl.sv
// tb_pe_ns_load_ctrl: table-driven directed vectors plus hand-written inst and reset sequences.
module tb_pe_ns_load_ctrl;
    logic        clk = 1'b0, reset = 1'b1;
    logic        cmd_valid, cmd_ready, wdata_valid, wdata_ready, wb_valid, wb_ready, inst_fifo_full;
    logic [2:0]  cmd_ns, wb_ns;
    logic [5:0]  cmd_base, wb_addr, data_wrt_addr, weight_wrt_addr, gradient_wrt_addr;
    logic [7:0]  cmd_count;
    logic [31:0] wdata, wb_data, inst_in, data_in, weight_in, gradient_in, meta_in;
    logic        inst_wrt, data_wrt, weight_wrt, gradient_wrt, meta_wrt, busy, done, err;
    logic [1:0]  meta_wrt_addr;

    always #5 clk = ~clk;

    pe_ns_load_ctrl dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ns(cmd_ns), .cmd_base(cmd_base), .cmd_count(cmd_count),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_ns(wb_ns), .wb_addr(wb_addr), .wb_data(wb_data),
        .inst_fifo_full(inst_fifo_full), .inst_wrt(inst_wrt), .inst_in(inst_in),
        .data_wrt(data_wrt), .data_wrt_addr(data_wrt_addr), .data_in(data_in),
        .weight_wrt(weight_wrt), .weight_wrt_addr(weight_wrt_addr), .weight_in(weight_in),
        .gradient_wrt(gradient_wrt), .gradient_wrt_addr(gradient_wrt_addr), .gradient_in(gradient_in),
        .meta_wrt(meta_wrt), .meta_wrt_addr(meta_wrt_addr), .meta_in(meta_in),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct packed {
        logic        cv;
        logic [2:0]  cns;
        logic [5:0]  cbase;
        logic [7:0]  ccnt;
        logic        dv;
        logic [31:0] dat;
        logic        wv;
        logic [2:0]  wns;
        logic [5:0]  waddr;
        logic [31:0] wdat;
        logic [2:0]  rdy;  // {cmd_ready, wdata_ready, wb_ready} before the edge
        logic [4:0]  stb;  // {meta, gradient, weight, data, inst} strobes after the edge
        logic [2:0]  flg;  // {done, err, busy} after the edge
        logic [2:0]  cn;   // namespace whose address/data is checked, 7 = none
        logic [5:0]  ca;
        logic [31:0] cd;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        cmd_valid = 0; cmd_ns = 0; cmd_base = 0; cmd_count = 0;
        wdata_valid = 0; wdata = 0; wb_valid = 0; wb_ns = 0; wb_addr = 0; wb_data = 0;
        inst_fifo_full = 0;
    endtask

    task automatic port_chk(input int r, input vec_t v);
        logic [31:0] a, d;
        case (v.cn)
            3'd1: begin a = {26'd0, data_wrt_addr};     d = data_in;     end
            3'd2: begin a = {26'd0, weight_wrt_addr};   d = weight_in;   end
            3'd3: begin a = {26'd0, gradient_wrt_addr}; d = gradient_in; end
            default: begin a = {30'd0, meta_wrt_addr};  d = meta_in;     end
        endcase
        chk($sformatf("row%0d addr", r), a, v.cn == 3'd4 ? {30'd0, v.ca[1:0]} : {26'd0, v.ca});
        chk($sformatf("row%0d data", r), d, v.cd);
    endtask

    logic [31:0] words [3];
    int          k, pulses, left;
    logic        prev, fire, seen_done;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_in();
        words[0] = 3; words[1] = 321; words[2] = 723;
        repeat (2) @(posedge clk);
        #1;
        chk("rst cmd_ready", cmd_ready, 1);
        chk("rst wdata_ready", wdata_ready, 0);
        chk("rst flags", {done, err, busy}, 0);
        chk("rst strobes", {meta_wrt, gradient_wrt, weight_wrt, data_wrt, inst_wrt}, 0);
        chk("rst data", data_in | weight_in | gradient_in | meta_in | inst_in, 0);
        chk("rst addr", {data_wrt_addr, weight_wrt_addr, gradient_wrt_addr, meta_wrt_addr}, 0);
        @(negedge clk) reset = 0;

        // data burst base 6 count 3
        vq.push_back(vec_t'{1,1,6,3, 0,0, 0,0,0,0, 3'b101,5'b00000,3'b001, 7,0,0});
        vq.push_back(vec_t'{0,0,0,0, 1,10, 0,0,0,0, 3'b011,5'b00010,3'b001, 1,6,10});
        vq.push_back(vec_t'{0,0,0,0, 1,11, 0,0,0,0, 3'b011,5'b00010,3'b001, 1,7,11});
        vq.push_back(vec_t'{0,0,0,0, 1,12, 0,0,0,0, 3'b011,5'b00010,3'b100, 1,8,12});
        vq.push_back(vec_t'{0,0,0,0, 0,0, 0,0,0,0, 3'b101,5'b00000,3'b000, 1,8,12});
        // meta wrap base 3 count 3 with a stall
        vq.push_back(vec_t'{1,4,3,3, 0,0, 0,0,0,0, 3'b101,5'b00000,3'b001, 7,0,0});
        vq.push_back(vec_t'{0,0,0,0, 1,100, 0,0,0,0, 3'b011,5'b10000,3'b001, 4,3,100});
        vq.push_back(vec_t'{0,0,0,0, 0,0, 0,0,0,0, 3'b011,5'b00000,3'b001, 4,3,100});
        vq.push_back(vec_t'{0,0,0,0, 1,101, 0,0,0,0, 3'b011,5'b10000,3'b001, 4,0,101});
        vq.push_back(vec_t'{0,0,0,0, 1,102, 0,0,0,0, 3'b011,5'b10000,3'b100, 4,1,102});
        // same-namespace conflict: weight burst base 20 count 4 vs writeback to weight 40
        vq.push_back(vec_t'{1,2,20,4, 0,0, 0,0,0,0, 3'b101,5'b00000,3'b001, 7,0,0});
        vq.push_back(vec_t'{0,0,0,0, 1,200, 1,2,40,777, 3'b001,5'b00100,3'b001, 2,40,777});
        vq.push_back(vec_t'{0,0,0,0, 1,200, 1,2,40,777, 3'b010,5'b00100,3'b001, 2,20,200});
        vq.push_back(vec_t'{0,0,0,0, 1,201, 1,2,40,777, 3'b001,5'b00100,3'b001, 2,40,777});
        vq.push_back(vec_t'{0,0,0,0, 1,201, 1,2,40,777, 3'b010,5'b00100,3'b001, 2,21,201});
        vq.push_back(vec_t'{0,0,0,0, 1,202, 1,2,40,777, 3'b001,5'b00100,3'b001, 2,40,777});
        vq.push_back(vec_t'{0,0,0,0, 1,202, 1,2,40,777, 3'b010,5'b00100,3'b001, 2,22,202});
        vq.push_back(vec_t'{0,0,0,0, 1,203, 1,2,40,777, 3'b001,5'b00100,3'b001, 2,40,777});
        vq.push_back(vec_t'{0,0,0,0, 1,203, 1,2,40,777, 3'b010,5'b00100,3'b100, 2,23,203});
        // cross-namespace: data burst with gradient writeback in the same cycle
        vq.push_back(vec_t'{1,1,0,1, 0,0, 0,0,0,0, 3'b101,5'b00000,3'b001, 7,0,0});
        vq.push_back(vec_t'{0,0,0,0, 1,55, 1,3,30,3222, 3'b011,5'b01010,3'b100, 3,30,3222});
        vq.push_back(vec_t'{0,0,0,0, 0,0, 0,0,0,0, 3'b101,5'b00000,3'b000, 1,0,55});
        // errors, idle writeback, zero-count command
        vq.push_back(vec_t'{1,6,0,2, 0,0, 0,0,0,0, 3'b101,5'b00000,3'b010, 7,0,0});
        vq.push_back(vec_t'{0,0,0,0, 0,0, 1,0,5,9, 3'b101,5'b00000,3'b010, 7,0,0});
        vq.push_back(vec_t'{0,0,0,0, 0,0, 1,7,5,9, 3'b101,5'b00000,3'b010, 7,0,0});
        vq.push_back(vec_t'{0,0,0,0, 0,0, 1,1,12,44, 3'b101,5'b00010,3'b000, 1,12,44});
        vq.push_back(vec_t'{1,2,1,0, 0,0, 0,0,0,0, 3'b101,5'b00000,3'b100, 7,0,0});
        vq.push_back(vec_t'{0,0,0,0, 0,0, 0,0,0,0, 3'b101,5'b00000,3'b000, 7,0,0});

        foreach (vq[i]) begin
            @(negedge clk);
            cmd_valid = vq[i].cv; cmd_ns = vq[i].cns; cmd_base = vq[i].cbase; cmd_count = vq[i].ccnt;
            wdata_valid = vq[i].dv; wdata = vq[i].dat;
            wb_valid = vq[i].wv; wb_ns = vq[i].wns; wb_addr = vq[i].waddr; wb_data = vq[i].wdat;
            #1 chk($sformatf("row%0d ready", i), {cmd_ready, wdata_ready, wb_ready}, vq[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d strobes", i), {meta_wrt, gradient_wrt, weight_wrt, data_wrt, inst_wrt}, vq[i].stb);
            chk($sformatf("row%0d flags", i), {done, err, busy}, vq[i].flg);
            if (vq[i].cn != 3'd7) port_chk(i, vq[i]);
        end

        // inst burst with fifo full for 4 cycles after the first write
        @(negedge clk);
        idle_in();
        cmd_valid = 1; cmd_ns = 0; cmd_base = 0; cmd_count = 3;
        @(posedge clk);
        #1 chk("inst busy", busy, 1);
        k = 0; pulses = 0; left = 0; prev = 0; seen_done = 0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            @(negedge clk);
            cmd_valid = 0;
            wdata_valid = k < 3;
            wdata = k < 3 ? words[k] : 32'd0;
            inst_fifo_full = left > 0;
            if (left > 0) left--;
            #1;
            fire = wdata_valid && wdata_ready;
            chk("inst ready gate", {31'd0, wdata_ready && (inst_fifo_full || inst_wrt)}, 0);
            @(posedge clk);
            #1;
            if (fire) k++;
            if (inst_wrt) begin
                pulses++;
                if (pulses <= 3) chk("inst data", inst_in, words[pulses-1]);
                else chk("inst extra pulse", pulses, 3);
                chk("inst back-to-back", {31'd0, prev}, 0);
                if (pulses == 1) left = 4;
            end
            prev = inst_wrt;
            if (done) begin
                seen_done = 1;
                chk("inst pulses at done", pulses, 3);
            end
        end
        chk("inst done seen", {31'd0, seen_done}, 1);

        // reset in the middle of a data burst
        @(negedge clk);
        idle_in();
        cmd_valid = 1; cmd_ns = 1; cmd_base = 0; cmd_count = 5;
        @(negedge clk);
        cmd_valid = 0; wdata_valid = 1; wdata = 1;
        @(negedge clk);
        wdata = 2;
        @(negedge clk);
        wdata = 3; reset = 1;
        @(posedge clk);
        #1;
        chk("rst mid strobe", {31'd0, data_wrt}, 0);
        chk("rst mid flags", {done, err, busy}, 0);
        chk("rst mid cmd_ready", cmd_ready, 1);
        @(negedge clk);
        reset = 0;
        #1 chk("post rst wdata_ready", wdata_ready, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1 chk("post rst quiet", {done, data_wrt}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
